// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - md_op codes, FSM state type and op classification helpers (MDU_MADD_EN)
package mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_madd_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`else
        return (op == 4'hF) && (op != 4'hF);
`endif
    endfunction

    // Ops that occupy the unit for a multi-cycle latency.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU)
            || is_madd_op(op);
    endfunction

    function automatic logic is_mdop(input logic [3:0] op);
        return is_long_op(op) || (op == MD_MTHI) || (op == MD_MTLO);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational product, quotient and remainder with zero/overflow handling
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod,
    output logic [WIDTH-1:0]   o_quot,
    output logic [WIDTH-1:0]   o_rem,
    output logic               o_div_zero
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic               w_signed;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;

    assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV)
                   || (i_op == MD_MADD) || (i_op == MD_MSUB);

    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    always_comb begin
        w_a_ext = w_signed ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
        w_b_ext = w_signed ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
        o_prod  = w_a_ext * w_b_ext;
    end

    always_comb begin
        o_div_zero = (i_b == '0);
        o_quot     = '0;
        o_rem      = '0;
        if (!o_div_zero) begin
            if (w_signed) begin
                if ((i_a == MOST_NEG) && (i_b == {WIDTH{1'b1}})) begin
                    o_quot = MOST_NEG;
                    o_rem  = '0;
                end else begin
                    o_quot = $signed(i_a) / $signed(i_b);
                    o_rem  = $signed(i_a) % $signed(i_b);
                end
            end else begin
                o_quot = i_a / i_b;
                o_rem  = i_a % i_b;
            end
        end
    end

endmodule

// File: rtl/mdu_pipelined.sv
// rtl/mdu_pipelined.sv - E-stage multiply/divide unit with HI/LO, cancel and done (MDU_MADD_EN)
module mdu_pipelined
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       md_op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

    mdu_state_t         r_state;
    mdu_state_t         w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic [WIDTH-1:0]   w_hi_next;
    logic [WIDTH-1:0]   w_lo_next;
    logic               w_issue;
    logic               w_launch;
    logic               w_complete;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic               w_div_zero;

    assign w_issue    = (r_state == S_IDLE) && start && !cancel;
    assign w_launch   = w_issue && is_long_op(md_op);
    assign w_complete = (r_state == S_RUN) && (r_cnt == '0) && !cancel;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .i_op       (r_op),
        .i_a        (r_a),
        .i_b        (r_b),
        .o_prod     (w_prod),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_state_next = S_RUN;
            S_RUN:   if (cancel || (r_cnt == '0)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            r_op  <= MD_NONE;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_launch) begin
            r_cnt <= ((md_op == MD_DIV) || (md_op == MD_DIVU)) ? DIV_LOAD : MUL_LOAD;
            r_op  <= md_op;
            r_a   <= a;
            r_b   <= b;
        end else if (r_state == S_RUN) begin
            r_cnt <= (cancel || (r_cnt == '0)) ? '0 : r_cnt - 1'b1;
        end
    end

    // Accumulating ops use HI/LO as they stand at the completion edge.
    always_comb begin
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (w_complete) begin
            case (r_op)
                MD_MULT, MD_MULTU: {w_hi_next, w_lo_next} = w_prod;
                MD_DIV, MD_DIVU: begin
                    if (!w_div_zero) begin
                        w_hi_next = w_rem;
                        w_lo_next = w_quot;
                    end
                end
`ifdef MDU_MADD_EN
                MD_MADD, MD_MADDU: {w_hi_next, w_lo_next} = {r_hi, r_lo} + w_prod;
                MD_MSUB, MD_MSUBU: {w_hi_next, w_lo_next} = {r_hi, r_lo} - w_prod;
`endif
                default: ;
            endcase
        end else if (w_issue) begin
            if (md_op == MD_MTHI) w_hi_next = a;
            if (md_op == MD_MTLO) w_lo_next = a;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_hi   <= w_hi_next;
            r_lo   <= w_lo_next;
            r_done <= w_complete;
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign done = r_done;

    always_ff @(posedge clk) begin
        if (reset && (r_state == S_RUN)) begin
            assert (!start) else $error("mdu_pipelined: start issued while busy");
        end
    end

endmodule

// File: doc/mdu_pipelined.md
Name: mdu_pipelined

Overview:
Parametrised multiply/divide unit with HI/LO registers, the successor to the fixed 32-bit start/busy MDU of the five-stage pipeline.
- Sits in the E stage. Accepts one operation per start pulse and holds busy for a configurable latency; stall control stalls dependent HI/LO reads on busy.
- New over the previous unit: generic operand width, independent multiply/divide latencies, a cancel input for exception flush, a done pulse, and defined divide-by-zero/overflow results.

Parameters:
WIDTH, 32, operand and HI/LO width in bits
MUL_LAT, 5, cycles busy stays high for mult/multu (>=1)
DIV_LAT, 10, cycles busy stays high for div/divu (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (0 = reset at the clk edge)
start  input  1  launch md_op this cycle
md_op  input  4  operation code (package constants)
cancel  input  1  flush: kill the in-flight or same-cycle operation
a  input  WIDTH  rs operand
b  input  WIDTH  rt operand
busy  output  1  operation in flight
done  output  1  one-cycle pulse when HI/LO take a new multiply/divide result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0 at the edge): hi=0, lo=0, busy=0, done=0, counter=0, state IDLE. Reset mid-operation discards the operation with no HI/LO write.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Launch: start=1 and cancel=0 in IDLE with a mult-class op sampled at edge k.
  - Operands latch and the result is computed from the latched values.
  - MULT: {hi,lo} = signed a*b (2*WIDTH). MULTU: unsigned.
  - DIV: lo = a/b truncated toward zero, hi = a%b with the sign of a. DIVU: unsigned.
- Latency: busy=1 for exactly LAT cycles after edge k. At the edge ending the last busy cycle, hi/lo update, busy falls, and done=1 for one cycle.
- Divide by zero: hi/lo keep old values; busy/done timing unchanged.
- Signed overflow: DIV of most-negative by -1 gives lo=most-negative, hi=0.
- MTHI/MTLO with start=1: hi (resp. lo) = a at the next edge. busy stays 0 and done stays 0.
- start while busy: ignored. Stall control guarantees this cannot happen; an assertion flags it.
- Undefined md_op with start: no effect.
- cancel in RUN: RUN->IDLE at the next edge, busy=0, no HI/LO write, no done.
- cancel with start in IDLE: the start is dropped, including MTHI/MTLO.
- Cancel beats completion: cancel in the final busy cycle suppresses the write.
- Counter: log2(max(MUL_LAT,DIV_LAT))+1 bits. Loads LAT-1 on launch and decrements in RUN; completion at 0. No wrap: the counter never decrements in IDLE.

Optional Feature:
MDU_MADD_EN
- Defined: MADD/MADDU/MSUB/MSUBU accepted with MUL_LAT latency.
  - {hi,lo} = {hi,lo} ± product, wrapping modulo 2^(2*WIDTH).
  - The accumulator base is the {hi,lo} value at the completion edge.
- Undefined: these codes behave as undefined ops (ignored, busy stays 0).

Decomposition:
Shared package mdu_pkg:
- md_op constants: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MADD=7, MD_MADDU=8, MD_MSUB=9, MD_MSUBU=10.
- Helper function is_mdop(op), used by the MainControl Start and Check logic.

One sub-module, mdu_arith: purely combinational product/quotient/remainder of the latched operands, including the zero and overflow special cases. The top holds the FSM, counter and HI/LO registers.

Test Plan:
- WIDTH=32, MULT a=-3 b=7 at edge k -> busy=1 for 5 cycles; at k+5 hi=FFFFFFFF, lo=FFFFFFEB, done pulses once.
- DIVU a=100 b=7 -> busy 10 cycles, then lo=14, hi=2. Then DIV a=-7 b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- DIV a=80000000 b=FFFFFFFF -> lo=80000000, hi=0. Then DIV a=5 b=0 -> hi/lo unchanged, done still pulses after 10 cycles.
- MULT launched, cancel in busy cycle 3 -> busy=0 next cycle, hi/lo unchanged, no done. MTLO a=1234 with cancel=1 -> lo unchanged.
- reset=0 in busy cycle 2 of a DIVU -> hi=lo=0, busy=0. A MTHI a=DEADBEEF next cycle -> hi=DEADBEEF, busy stays 0.
- With MDU_MADD_EN: MTHI 0, MTLO FFFFFFFF, then MADDU a=1 b=1 -> hi=1, lo=0 after 5 cycles.
